// File: rtl/pcie_scr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcie_scr_pkg
// Desc     : Shared constants, symbol codes and types for the multi-gen scrambler
// Revision : 1.0 - initial release
// ============================================================================
package pcie_scr_pkg;

    localparam logic [15:0] c_g1_seed    = 16'hFFFF;
    localparam logic [15:0] c_g1_taps    = 16'h0039;
    localparam logic [22:0] c_g3_taps    = 23'h210125;

    localparam logic [7:0]  c_com_sym    = 8'hBC;
    localparam logic [7:0]  c_skp_sym    = 8'h1C;
    localparam logic [7:0]  c_g3_skp_sym = 8'hAA;
    localparam logic [7:0]  c_eieos_sym  = 8'h00;

    localparam logic [1:0]  c_sync_data  = 2'b10;
    localparam logic [1:0]  c_sync_os    = 2'b01;

    typedef enum logic [2:0] {
        OS_NONE  = 3'd0,
        OS_DATA  = 3'd1,
        OS_SKP   = 3'd2,
        OS_EIEOS = 3'd3,
        OS_OTHER = 3'd4
    } os_kind_t;

    function automatic logic [22:0] g3_seed(input int lane);
        case (lane)
            0:       return 23'h1DBFBC;
            1:       return 23'h0607BB;
            2:       return 23'h1EC760;
            3:       return 23'h18C0DB;
            4:       return 23'h010F12;
            5:       return 23'h19CFC9;
            6:       return 23'h0277CE;
            7:       return 23'h1BB807;
            default: return 23'h1DBFBC;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_lfsr_byte_step.sv
`default_nettype none
// ============================================================================
// Module   : pcie_lfsr_byte_step
// Desc     : Combinational 8-step Galois LFSR advance producing one key byte
// Revision : 1.0 - initial release
// ============================================================================
module pcie_lfsr_byte_step #(
    parameter int           W = 16,
    parameter logic [W-1:0] T = '0
) (
    input  logic [W-1:0] i_lfsr,
    output logic [W-1:0] o_lfsr,
    output logic [7:0]   o_key
);
    import pcie_scr_pkg::*;

    logic [W-1:0] w_s;

    always_comb begin
        w_s   = i_lfsr;
        o_key = 8'h00;
        for (int b = 0; b < 8; b++) begin
            o_key[b] = w_s[W-1];
            w_s      = {w_s[W-2:0], 1'b0} ^ (w_s[W-1] ? T : '0);
        end
        o_lfsr = w_s;
    end

endmodule
`default_nettype wire

// File: rtl/pcie_multigen_scrambler.sv
`default_nettype none
// ============================================================================
// Module   : pcie_multigen_scrambler
// Desc     : One-lane Gen1/2 + Gen3 TX scrambler, BYTES symbols per beat
// Revision : 1.0 - initial release
// ============================================================================
module pcie_multigen_scrambler #(
    parameter int BYTES    = 4,
    parameter int LANE_NUM = 0,
    parameter int GEN3_EN  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 gen_sel_i,
    input  logic                 scramble_enable_i,
    input  logic                 valid_i,
    input  logic [BYTES-1:0]     datak_i,
    input  logic [BYTES-1:0]     training_sequence_i,
    input  logic                 block_start_i,
    input  logic [1:0]           sync_hdr_i,
    input  logic [8*BYTES-1:0]   data_i,
    output logic                 valid_o,
    output logic [BYTES-1:0]     datak_o,
    output logic [1:0]           sync_hdr_o,
    output logic                 block_start_o,
    output logic [8*BYTES-1:0]   data_o,
    output logic                 blk_err_o
);
    import pcie_scr_pkg::*;

    localparam int              BEATS       = 16 / BYTES;
    localparam int              CW          = $clog2(BEATS);
    localparam logic [CW-1:0]   c_last_beat = CW'(BEATS - 1);
    localparam logic [22:0]     c_seed3     = g3_seed(LANE_NUM);

    logic               r_gen_q;
    logic [15:0]        r_lfsr1;
    logic [22:0]        r_lfsr3;
    logic [CW-1:0]      r_beat_cnt;
    os_kind_t           r_os_kind;

    logic               w_gen, w_err, w_last, w_g3_adv, w_g3_scr, w_eieos_reseed;
    os_kind_t           w_kind, w_os_next;
    logic [CW-1:0]      w_cnt_next;
    logic [15:0]        w_g1_state [BYTES+1];
    logic [22:0]        w_g3_state [BYTES+1];
    logic [8*BYTES-1:0] w_g1_data, w_g3_data;

    assign w_gen = (GEN3_EN != 0) && gen_sel_i;

    // Gen1/2 byte chain: COM reseeds for the following byte, SKP holds the state
    assign w_g1_state[0] = r_lfsr1;
    for (genvar b = 0; b < BYTES; b++) begin : g_g1_byte
        logic [15:0] w_next;
        logic [7:0]  w_key, w_sym;
        logic        w_com, w_skp, w_bypass;

        assign w_sym    = data_i[8*b +: 8];
        assign w_com    = datak_i[b] && (w_sym == c_com_sym);
        assign w_skp    = datak_i[b] && (w_sym == c_skp_sym);
        assign w_bypass = datak_i[b] || training_sequence_i[b] || !scramble_enable_i;

        pcie_lfsr_byte_step #(.W(16), .T(c_g1_taps)) u_step (
            .i_lfsr (w_g1_state[b]),
            .o_lfsr (w_next),
            .o_key  (w_key)
        );

        assign w_g1_state[b+1]     = w_com ? c_g1_seed : (w_skp ? w_g1_state[b] : w_next);
        assign w_g1_data[8*b +: 8] = w_bypass ? w_sym : (w_sym ^ w_key);
    end

    // Block classification; a misplaced start is still honoured as a start
    always_comb begin
        w_err      = 1'b0;
        w_kind     = r_os_kind;
        w_os_next  = r_os_kind;
        w_cnt_next = r_beat_cnt;
        if (block_start_i) begin
            if (sync_hdr_i == c_sync_data) begin
                w_kind = OS_DATA;
            end else if (sync_hdr_i == c_sync_os) begin
                if (data_i[7:0] == c_g3_skp_sym)      w_kind = OS_SKP;
                else if (data_i[7:0] == c_eieos_sym)  w_kind = OS_EIEOS;
                else                                  w_kind = OS_OTHER;
            end else begin
                w_kind = OS_NONE;
                w_err  = 1'b1;
            end
            if (r_beat_cnt != '0) w_err = 1'b1;
            w_os_next  = w_kind;
            w_cnt_next = CW'(1);
        end else if (r_beat_cnt == '0) begin
            w_kind = OS_NONE;
            w_err  = 1'b1;
        end else begin
            w_cnt_next = (r_beat_cnt == c_last_beat) ? '0 : r_beat_cnt + 1'b1;
        end
    end

    assign w_last         = !block_start_i && (r_beat_cnt == c_last_beat);
    assign w_eieos_reseed = (w_kind == OS_EIEOS) && w_last;
    assign w_g3_adv       = (w_kind == OS_DATA) || (w_kind == OS_EIEOS) || (w_kind == OS_OTHER);
    assign w_g3_scr       = (w_kind == OS_DATA) && scramble_enable_i;

    assign w_g3_state[0] = r_lfsr3;
    if (GEN3_EN != 0) begin : g_gen3
        for (genvar b = 0; b < BYTES; b++) begin : g_g3_byte
            logic [22:0] w_next;
            logic [7:0]  w_key;

            pcie_lfsr_byte_step #(.W(23), .T(c_g3_taps)) u_step (
                .i_lfsr (w_g3_state[b]),
                .o_lfsr (w_next),
                .o_key  (w_key)
            );

            assign w_g3_state[b+1]     = w_g3_adv ? w_next : w_g3_state[b];
            assign w_g3_data[8*b +: 8] = data_i[8*b +: 8] ^ (w_g3_scr ? w_key : 8'h00);
        end
    end else begin : g_no_gen3
        for (genvar b = 0; b < BYTES; b++) begin : g_g3_byte
            assign w_g3_state[b+1] = w_g3_state[b];
        end
        assign w_g3_data = data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gen_q       <= 1'b0;
            r_lfsr1       <= c_g1_seed;
            r_lfsr3       <= c_seed3;
            r_beat_cnt    <= '0;
            r_os_kind     <= OS_NONE;
            valid_o       <= 1'b0;
            datak_o       <= '0;
            sync_hdr_o    <= 2'b00;
            block_start_o <= 1'b0;
            data_o        <= '0;
            blk_err_o     <= 1'b0;
        end else begin
            r_gen_q       <= w_gen;
            valid_o       <= valid_i;
            datak_o       <= datak_i;
            sync_hdr_o    <= sync_hdr_i;
            block_start_o <= block_start_i;
            blk_err_o     <= 1'b0;
            if (valid_i) data_o <= w_gen ? w_g3_data : w_g1_data;
            if (w_gen != r_gen_q) begin
                r_lfsr1    <= c_g1_seed;
                r_lfsr3    <= c_seed3;
                r_beat_cnt <= '0;
                r_os_kind  <= OS_NONE;
            end else if (valid_i) begin
                if (w_gen) begin
                    r_lfsr3    <= w_eieos_reseed ? c_seed3 : w_g3_state[BYTES];
                    r_beat_cnt <= w_cnt_next;
                    r_os_kind  <= w_os_next;
                    blk_err_o  <= w_err;
                end else begin
                    r_lfsr1    <= w_g1_state[BYTES];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pcie_multigen_scrambler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_multigen_scrambler
// Desc     : Directed self-checking bench, BYTES = 4, lanes 0 and 3
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_multigen_scrambler;

    logic        clk = 1'b0;
    logic        rst, gen_sel, scr_en, valid, block_start;
    logic [3:0]  datak, ts_in;
    logic [1:0]  sync_hdr;
    logic [31:0] data;

    logic        valid_o0, block_start_o0, blk_err_o0;
    logic [3:0]  datak_o0;
    logic [1:0]  sync_hdr_o0;
    logic [31:0] data_o0;
    logic        valid_o3, block_start_o3, blk_err_o3;
    logic [3:0]  datak_o3;
    logic [1:0]  sync_hdr_o3;
    logic [31:0] data_o3;

    int n_pass = 0, n_fail = 0, n_total = 0;
    logic [22:0] m0, m3;

    always #5 clk = ~clk;

    pcie_multigen_scrambler #(.BYTES(4), .LANE_NUM(0), .GEN3_EN(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .gen_sel_i(gen_sel), .scramble_enable_i(scr_en),
        .valid_i(valid), .datak_i(datak), .training_sequence_i(ts_in),
        .block_start_i(block_start), .sync_hdr_i(sync_hdr), .data_i(data),
        .valid_o(valid_o0), .datak_o(datak_o0), .sync_hdr_o(sync_hdr_o0),
        .block_start_o(block_start_o0), .data_o(data_o0), .blk_err_o(blk_err_o0)
    );

    pcie_multigen_scrambler #(.BYTES(4), .LANE_NUM(3), .GEN3_EN(1)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .gen_sel_i(gen_sel), .scramble_enable_i(scr_en),
        .valid_i(valid), .datak_i(datak), .training_sequence_i(ts_in),
        .block_start_i(block_start), .sync_hdr_i(sync_hdr), .data_i(data),
        .valid_o(valid_o3), .datak_o(datak_o3), .sync_hdr_o(sync_hdr_o3),
        .block_start_o(block_start_o3), .data_o(data_o3), .blk_err_o(blk_err_o3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Gen3 reference: 32 serial LFSR steps, returns {next_state, key}
    function automatic logic [54:0] g3_beat(input logic [22:0] s);
        logic [22:0] x;
        logic [31:0] k;
        x = s;
        k = '0;
        for (int i = 0; i < 32; i++) begin
            k[i] = x[22];
            x    = {x[21:0], 1'b0} ^ (x[22] ? 23'h210125 : 23'h0);
        end
        return {x, k};
    endfunction

    task automatic beat(input logic [3:0] k, input logic [3:0] ts, input logic bs,
                        input logic [1:0] sh, input logic [31:0] d);
        valid = 1'b1; datak = k; ts_in = ts; block_start = bs; sync_hdr = sh; data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = 1'b0; block_start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic g1(input logic [3:0] k, input logic [3:0] ts, input logic [31:0] d);
        beat(k, ts, 1'b0, 2'b00, d);
    endtask

    task automatic g3_scr(input string tag, input logic bs, input logic [31:0] d, input logic chk3);
        logic [31:0] k0, k3;
        {m0, k0} = g3_beat(m0);
        {m3, k3} = g3_beat(m3);
        beat(4'h0, 4'h0, bs, 2'b10, d);
        check(tag, data_o0, d ^ k0);
        if (chk3) check({tag, "_l3"}, data_o3, d ^ k3);
    endtask

    task automatic g3_pass(input string tag, input logic bs, input logic [1:0] sh,
                           input logic [31:0] d, input logic adv);
        logic [31:0] k;
        if (adv) begin
            {m0, k} = g3_beat(m0);
            {m3, k} = g3_beat(m3);
        end
        beat(4'h0, 4'h0, bs, sh, d);
        check(tag, data_o0, d);
    endtask

    initial begin
        rst = 1'b1; gen_sel = 1'b0; scr_en = 1'b1; valid = 1'b0; block_start = 1'b0;
        datak = '0; ts_in = '0; sync_hdr = 2'b00; data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data_o0, 32'h0);
        check("rst_ctl", {valid_o0, datak_o0, sync_hdr_o0, block_start_o0, blk_err_o0}, 9'h0);
        rst = 1'b0;
        idle();

        // Gen1/2 stream from reset
        g1(4'h0, 4'h0, 32'h0);
        check("g1_beat0", data_o0, 32'h14C017FF);
        check("g1_valid", valid_o0, 1'b1);
        g1(4'h0, 4'h0, 32'h0);
        check("g1_beat1", data_o0, 32'h8202E7B2);
        idle();
        check("idle_valid", valid_o0, 1'b0);
        check("idle_hold", data_o0, 32'h8202E7B2);

        g1(4'h0, 4'h0, 32'h12345678);
        g1(4'h0, 4'h0, 32'h9ABCDEF0);
        g1(4'b0001, 4'h0, 32'h000000BC);
        check("g1_com", data_o0, 32'hC017FFBC);
        check("g1_datak_o", datak_o0, 4'b0001);
        g1(4'h0, 4'h0, 32'h0);
        check("g1_after_com", data_o0, 32'h02E7B214);

        // COM then SKP in the same beat; SKP must not consume key
        g1(4'b0011, 4'h0, 32'h00001CBC);
        check("g1_skp", data_o0, 32'h17FF1CBC);
        g1(4'h0, 4'h0, 32'h0);
        check("g1_after_skp", data_o0, 32'hE7B214C0);

        g1(4'b0001, 4'h0, 32'h000000BC);
        check("g1_com2", data_o0, 32'hC017FFBC);
        g1(4'h0, 4'b0010, 32'h00005500);
        check("g1_ts", data_o0, 32'h02E75514);

        scr_en = 1'b0;
        g1(4'b0001, 4'h0, 32'h000000BC);
        check("g1_bypass", data_o0, 32'h000000BC);
        scr_en = 1'b1;
        g1(4'h0, 4'h0, 32'h0);
        check("g1_after_bypass", data_o0, 32'h02E7B214);

        g1(4'b0011, 4'h0, 32'h00007CBC);
        check("g1_other_k", data_o0, 32'hC0177CBC);
        g1(4'h0, 4'h0, 32'hFFFFFFFF);
        check("g1_ones", data_o0, 32'hFD184DEB);

        // Gen3: switch with valid low reseeds both LFSRs
        gen_sel = 1'b1;
        idle();
        idle();
        m0 = 23'h1DBFBC;
        m3 = 23'h18C0DB;

        g3_scr("g3_a0", 1'b1, 32'h0, 1'b1);
        check("g3_sync_o", sync_hdr_o0, 2'b10);
        check("g3_bs_o", block_start_o0, 1'b1);
        g3_scr("g3_a1", 1'b0, 32'h11223344, 1'b0);
        g3_scr("g3_a2", 1'b0, 32'h55667788, 1'b0);
        g3_scr("g3_a3", 1'b0, 32'h99AABBCC, 1'b0);
        check("g3_a_err", blk_err_o0, 1'b0);

        g3_pass("g3_skp0", 1'b1, 2'b01, 32'hAAAAAAAA, 1'b0);
        g3_pass("g3_skp1", 1'b0, 2'b01, 32'hAAAAAAAA, 1'b0);
        g3_pass("g3_skp2", 1'b0, 2'b01, 32'hAAAAAAAA, 1'b0);
        g3_pass("g3_skp3", 1'b0, 2'b01, 32'hAAAAAAAA, 1'b0);

        g3_scr("g3_b0", 1'b1, 32'hA5A5A5A5, 1'b0);
        g3_scr("g3_b1", 1'b0, 32'h0, 1'b0);
        g3_scr("g3_b2", 1'b0, 32'h0F0F0F0F, 1'b0);
        g3_scr("g3_b3", 1'b0, 32'h0, 1'b1);

        g3_pass("g3_eieos0", 1'b1, 2'b01, 32'hFF00FF00, 1'b1);
        g3_pass("g3_eieos1", 1'b0, 2'b01, 32'hFF00FF00, 1'b1);
        g3_pass("g3_eieos2", 1'b0, 2'b01, 32'hFF00FF00, 1'b1);
        g3_pass("g3_eieos3", 1'b0, 2'b01, 32'hFF00FF00, 1'b1);
        m0 = 23'h1DBFBC;
        m3 = 23'h18C0DB;
        g3_scr("g3_c0", 1'b1, 32'h0, 1'b1);
        g3_scr("g3_c1", 1'b0, 32'hDEADBEEF, 1'b1);
        g3_scr("g3_c2", 1'b0, 32'h0, 1'b1);
        g3_scr("g3_c3", 1'b0, 32'h0, 1'b1);

        // Early block start on beat 2 of 4
        g3_scr("g3_mis0", 1'b1, 32'h0, 1'b0);
        g3_scr("g3_mis1", 1'b0, 32'h0, 1'b0);
        g3_scr("g3_mis2", 1'b1, 32'h0, 1'b0);
        check("g3_mis_err", blk_err_o0, 1'b1);
        g3_scr("g3_mis3", 1'b0, 32'h0, 1'b0);
        check("g3_mis_err_pulse", blk_err_o0, 1'b0);
        g3_scr("g3_mis4", 1'b0, 32'h0, 1'b0);
        g3_scr("g3_mis5", 1'b0, 32'h0, 1'b0);
        g3_scr("g3_resync0", 1'b1, 32'h12345678, 1'b1);
        check("g3_resync_err", blk_err_o0, 1'b0);
        g3_scr("g3_resync1", 1'b0, 32'h0, 1'b0);
        g3_scr("g3_resync2", 1'b0, 32'h0, 1'b0);
        g3_scr("g3_resync3", 1'b0, 32'h0, 1'b0);

        // Missing block start: bypass, LFSR held
        g3_pass("g3_nostart", 1'b0, 2'b10, 32'h13572468, 1'b0);
        check("g3_nostart_err", blk_err_o0, 1'b1);
        g3_scr("g3_d0", 1'b1, 32'h0, 1'b0);
        check("g3_d0_err", blk_err_o0, 1'b0);
        g3_scr("g3_d1", 1'b0, 32'h0, 1'b0);
        g3_scr("g3_d2", 1'b0, 32'h0, 1'b0);
        g3_scr("g3_d3", 1'b0, 32'h0, 1'b0);

        // Illegal sync header: whole block bypassed with LFSR held
        g3_pass("g3_ill0", 1'b1, 2'b11, 32'hDEADBEEF, 1'b0);
        check("g3_ill_err", blk_err_o0, 1'b1);
        g3_pass("g3_ill1", 1'b0, 2'b11, 32'h01020304, 1'b0);
        g3_pass("g3_ill2", 1'b0, 2'b11, 32'h05060708, 1'b0);
        g3_pass("g3_ill3", 1'b0, 2'b11, 32'h090A0B0C, 1'b0);
        g3_scr("g3_e0", 1'b1, 32'h0, 1'b1);

        // Reset in the middle of a block
        g3_scr("g3_f1", 1'b0, 32'h0, 1'b0);
        valid = 1'b0;
        rst = 1'b1;
        #2;
        check("midrst_data", data_o0, 32'h0);
        check("midrst_ctl", {valid_o0, sync_hdr_o0, block_start_o0, blk_err_o0}, 5'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        m0 = 23'h1DBFBC;
        m3 = 23'h18C0DB;
        g3_scr("g3_post_rst", 1'b1, 32'h0, 1'b1);
        check("g3_post_rst_err", blk_err_o0, 1'b0);

        idle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcie_multigen_scrambler.md
Name: pcie_multigen_scrambler

Overview:
Parametrised successor to the fixed 32-bit Gen1/Gen3 scrambler pair. One lane, BYTES symbols per beat. Holds both LFSRs (Gen1/2 8b10b, Gen3 128b/130b) in one block, selects the active one at runtime, and implements per-lane Gen3 seeding, COM/EIEOS reseed, SKP freeze and block tracking. Sits between the lane framer and the encoder/gearbox in the PHY TX path.

Parameters:
BYTES, 4, symbols per beat; legal values 1, 2, 4, 8; 16 % BYTES == 0.
LANE_NUM, 0, lane index 0..7; selects the Gen3 seed.
GEN3_EN, 1, 0 removes the Gen3 LFSR and block logic; gen_sel_i is then ignored and treated as 0.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
gen_sel_i  in  1  0 = Gen1/2, 1 = Gen3; change only while valid_i = 0
scramble_enable_i  in  1  0 = bypass data; the LFSR still advances
valid_i  in  1  beat qualifier; LFSRs advance only on valid beats
datak_i  in  BYTES  per-byte K flag (Gen1/2)
training_sequence_i  in  BYTES  per-byte TS marker; byte bypassed, LFSR advances (Gen1/2)
block_start_i  in  1  Gen3 first beat of a 16-byte block
sync_hdr_i  in  2  Gen3 sync header: 2'b10 data, 2'b01 ordered set; sampled on block_start_i
data_i  in  8*BYTES  symbols, byte 0 = earliest
valid_o  out  1  registered valid_i
datak_o  out  BYTES  registered datak_i
sync_hdr_o  out  2  registered sync_hdr_i
block_start_o  out  1  registered block_start_i
data_o  out  8*BYTES  scrambled symbols
blk_err_o  out  1  one-cycle pulse on block misalignment

Behaviour:
- Latency is 1 cycle, all outputs registered. Reset values: all outputs 0, lfsr1 = 16'hFFFF, lfsr3 = SEED[LANE_NUM], beat_cnt = 0, os_kind = NONE.
- Byte step, width W with taps T and key bit = lfsr[W-1], repeated 8 times: lfsr <= {lfsr[W-2:0],1'b0} ^ (lfsr[W-1] ? T : 0). Key bit i is XORed into data bit i, LSB first.
- Gen1 LFSR: W = 16, T = 16'h0039.
- Gen3 LFSR: W = 23, T = 23'h210125.
- Gen3 seeds, lanes 0..7: 1DBFBC, 0607BB, 1EC760, 18C0DB, 010F12, 19CFC9, 0277CE, 1BB807.
- Bytes within a beat are processed in order as a combinational chain. The state after the last byte is registered.
- Gen1/2, per byte:
  - K and 0xBC (COM): output unscrambled; LFSR reseeds to FFFF for the next byte.
  - K and 0x1C (SKP): output unscrambled; LFSR held.
  - Other K, or a TS byte: output unscrambled; LFSR advances.
  - D byte: scrambled if scramble_enable_i = 1; LFSR advances.
- Gen3 block tracking:
  - beat_cnt counts 0..16/BYTES-1 and wraps.
  - block_start_i with beat_cnt != 0: blk_err_o pulses, beat_cnt restarts at 1, the beat is treated as a block start.
  - beat_cnt == 0 without block_start_i: blk_err_o pulses, the beat is passed unscrambled with LFSR held.
- Gen3 on the first beat of a block:
  - sync 2'b10: DATA block; all bytes scrambled and LFSR advances.
  - sync 2'b01 with byte0 0xAA: SKP block; all bytes bypassed and LFSR frozen for the whole block.
  - sync 2'b01 with byte0 0x00: EIEOS block; bytes bypassed, LFSR advances, then lfsr3 reseeds after the block's last beat.
  - Other 2'b01: bypassed, LFSR advances.
  - Illegal sync (00/11): bypassed, LFSR held, blk_err_o pulses.
- Gen3 ignores datak_i and training_sequence_i. Gen1/2 ignores the block inputs and leaves beat_cnt at 0.
- A change of gen_sel_i, registered against the previous value, reseeds both LFSRs and clears beat_cnt.
- valid_i = 0: no LFSR or counter change; data_o holds its previous value and valid_o = 0.
- Reset mid-block returns to the reset state immediately; no partial-block recovery.

Decomposition:
- Package pcie_scr_pkg holds:
  - seed table, tap constants, symbol codes (COM 8'hBC, SKP 8'h1C, G3 SKP 8'hAA, EIEOS 8'h00);
  - sync header codes;
  - os_kind enum (NONE, DATA, SKP, EIEOS, OTHER).
- Sub-module pcie_lfsr_byte_step: combinational, parameters W and T; in lfsr, out next lfsr and 8-bit key. Instantiated BYTES times per generation.

Test Plan:
- Gen1, BYTES = 4, reset, then a beat of four D 0x00 bytes -> data_o = bytes FF,17,C0,14 (byte0..3); the next beat continues the sequence with B2,E7,02,82.
- Gen1 beat K=1000, data BC,00,00,00, sent after several data beats -> byte0 = BC unchanged; bytes1..3 = FF,17,C0.
- Gen1 SKP byte inserted mid-stream -> SKP passes unchanged; the following D bytes match a stream with the SKP removed.
- Gen3, LANE_NUM = 0, DATA block then SKP block (AA x16) then DATA block -> SKP bytes unchanged; the second DATA block keys continue exactly from where the first ended (compare with the C model).
- Gen3 EIEOS block then DATA block, LANE_NUM = 3 -> DATA key equals a fresh seed 18C0DB sequence.
- Gen3 block_start_i asserted on beat 2 of 4 -> blk_err_o pulses for one cycle; beat_cnt resyncs and the next block scrambles correctly.
